// File: rtl/capsense_scanner.sv
// Round-robin capacitive pad scanner: discharge, release, count prescaled ticks until the pad reads
// high, learn per-pad baselines during calibration and publish a hysteretic touched bitmap.
module capsense_scanner #(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned CntW       = 8,
  parameter int unsigned TickDiv    = 32,
  parameter int unsigned DriveTicks = 3,
  parameter int unsigned Timeout    = 255,
  parameter int unsigned Thresh     = 3,
  parameter int unsigned Hyst       = 1,
  parameter int unsigned CalScans   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [NumCh-1:0] sense_i,
  output logic [NumCh-1:0] drive_oe_o,
  output logic [CntW-1:0]  count_o,
  output logic [2:0]       count_ch_o,
  output logic             count_valid_o,
  output logic             timeout_o,
  output logic [NumCh-1:0] touched_o,
  output logic             cal_done_o,
  output logic             scan_done_o
);

  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned PreW = $clog2(TickDiv);
  localparam int unsigned DcW  = $clog2(DriveTicks + 1);
  localparam int unsigned ScW  = $clog2(CalScans + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StStore} state_e;

  state_e state_q, state_d;

  logic [PreW-1:0]  pre_q;
  logic             tick;
  logic [NumCh-1:0] sync1_q, sync2_q;

  logic [ChW-1:0]   ch_q, ch_d;
  logic [DcW-1:0]   dcnt_q, dcnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             to_q, to_d;
  logic [CntW-1:0]  base_q [NumCh];
  logic [CntW-1:0]  base_d [NumCh];
  logic [NumCh-1:0] touched_q, touched_d;
  logic             cal_done_q, cal_done_d;
  logic [ScW-1:0]   scans_q, scans_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [2:0]       count_ch_q, count_ch_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             scan_done_q, scan_done_d;

  logic             sense_cur;
  logic             drive_last;
  logic             cnt_last;
  logic             ch_last;
  logic [CntW:0]    assert_lvl;
  logic [CntW:0]    release_lvl;
  logic [CntW:0]    cnt_ext;

  // Prescaler: tick is the single cycle where the divider wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PreW'(1);
    end
  end

  assign tick = (pre_q == PreW'(TickDiv - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sense_i;
      sync2_q <= sync1_q;
    end
  end

  assign sense_cur  = sync2_q[ch_q];
  assign drive_last = (dcnt_q == DcW'(DriveTicks - 1));
  assign cnt_last   = (cnt_q == CntW'(Timeout - 1));
  assign ch_last    = (ch_q == ChW'(NumCh - 1));

  // One extra bit so a baseline near full scale cannot wrap the threshold.
  assign cnt_ext     = {1'b0, cnt_q};
  assign assert_lvl  = {1'b0, base_q[ch_q]} + (CntW + 1)'(Thresh);
  assign release_lvl = assert_lvl - (CntW + 1)'(Hyst);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (tick && enable_i) state_d = StDrive;
      end
      StDrive: begin
        if (tick && drive_last) state_d = StSample;
      end
      StSample: begin
        if (tick && (sense_cur || cnt_last)) state_d = StStore;
      end
      StStore: begin
        state_d = enable_i ? StDrive : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: only the active channel's pad is pulled low, and only while driving.
  always_comb begin
    drive_oe_o = '0;
    unique case (state_q)
      StDrive: drive_oe_o = NumCh'(1) << ch_q;
      default: drive_oe_o = '0;
    endcase
  end

  // Datapath next state
  always_comb begin
    ch_d        = ch_q;
    dcnt_d      = dcnt_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    base_d      = base_q;
    touched_d   = touched_q;
    cal_done_d  = cal_done_q;
    scans_d     = scans_q;
    count_d     = count_q;
    count_ch_d  = count_ch_q;
    timeout_d   = timeout_q;
    valid_d     = 1'b0;
    scan_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Each fresh start relearns the baselines from scratch.
        if (tick && enable_i) begin
          ch_d       = '0;
          dcnt_d     = '0;
          touched_d  = '0;
          cal_done_d = 1'b0;
          scans_d    = '0;
          for (int i = 0; i < NumCh; i++) begin
            base_d[i] = '1;
          end
        end
      end
      StDrive: begin
        if (tick) begin
          if (drive_last) begin
            cnt_d = '0;
            to_d  = 1'b0;
          end else begin
            dcnt_d = dcnt_q + DcW'(1);
          end
        end
      end
      StSample: begin
        if (tick && !sense_cur) begin
          if (cnt_last) begin
            cnt_d = CntW'(Timeout);
            to_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStore: begin
        count_d    = cnt_q;
        count_ch_d = 3'(ch_q);
        timeout_d  = to_q;
        valid_d    = 1'b1;

        if (!cal_done_q) begin
          if (cnt_q < base_q[ch_q]) base_d[ch_q] = cnt_q;
        end else if (cnt_ext >= assert_lvl) begin
          touched_d[ch_q] = 1'b1;
        end else if (cnt_ext < release_lvl) begin
          touched_d[ch_q] = 1'b0;
        end

        if (ch_last) begin
          scan_done_d = 1'b1;
          if (!cal_done_q) begin
            scans_d = scans_q + ScW'(1);
            if ((scans_q + ScW'(1)) == ScW'(CalScans)) cal_done_d = 1'b1;
          end
        end

        if (enable_i) begin
          ch_d   = ch_last ? '0 : ch_q + ChW'(1);
          dcnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q        <= '0;
      dcnt_q      <= '0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
      touched_q   <= '0;
      cal_done_q  <= 1'b0;
      scans_q     <= '0;
      count_q     <= '0;
      count_ch_q  <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      scan_done_q <= 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        base_q[i] <= '1;
      end
    end else begin
      ch_q        <= ch_d;
      dcnt_q      <= dcnt_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      touched_q   <= touched_d;
      cal_done_q  <= cal_done_d;
      scans_q     <= scans_d;
      count_q     <= count_d;
      count_ch_q  <= count_ch_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      scan_done_q <= scan_done_d;
      for (int i = 0; i < NumCh; i++) begin
        base_q[i] <= base_d[i];
      end
    end
  end

  assign count_o       = count_q;
  assign count_ch_o    = count_ch_q;
  assign count_valid_o = valid_q;
  assign timeout_o     = timeout_q;
  assign touched_o     = touched_q;
  assign cal_done_o    = cal_done_q;
  assign scan_done_o   = scan_done_q;

endmodule

// File: tb/tb_capsense_scanner.sv
// Bench for capsense_scanner: RC pad models with per-measurement rise times and glitches feed a
// reference model whose predicted store records are popped and compared on every count_valid.
module tb_capsense_scanner;

  localparam int NumCh      = 4;
  localparam int CntW       = 8;
  localparam int TickDiv    = 8;
  localparam int DriveTicks = 3;
  localparam int Timeout    = 255;
  localparam int Thresh     = 3;
  localparam int Hyst       = 1;
  localparam int CalScans   = 4;
  localparam int ScanBudget = 6000;

  typedef struct packed {
    logic [2:0]       ch;
    logic [CntW-1:0]  cnt;
    logic             to;
    logic [NumCh-1:0] touched;
    logic             cal;
    logic             sd;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NumCh-1:0] sense;
  logic [NumCh-1:0] drive_oe;
  logic [CntW-1:0]  count_out;
  logic [2:0]       count_ch;
  logic             count_valid;
  logic             timeout;
  logic [NumCh-1:0] touched;
  logic             cal_done;
  logic             scan_done;

  capsense_scanner #(
    .NumCh     (NumCh),
    .CntW      (CntW),
    .TickDiv   (TickDiv),
    .DriveTicks(DriveTicks),
    .Timeout   (Timeout),
    .Thresh    (Thresh),
    .Hyst      (Hyst),
    .CalScans  (CalScans)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .sense_i      (sense),
    .drive_oe_o   (drive_oe),
    .count_o      (count_out),
    .count_ch_o   (count_ch),
    .count_valid_o(count_valid),
    .timeout_o    (timeout),
    .touched_o    (touched),
    .cal_done_o   (cal_done),
    .scan_done_o  (scan_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  int   nvalid = 0;
  int   nscan = 0;
  int   nrel = 0;
  int   last_rel_ch = -1;

  // r: low ticks before the pad reads high; g: release-relative clk of a 1-clk glitch (0 = none)
  int r_next[NumCh];
  int g_next[NumCh];
  int r_act[NumCh];
  int g_act[NumCh];
  int rel[NumCh];

  int               base_m[NumCh];
  logic [NumCh-1:0] touch_m;
  bit               cal_m;
  int               scans_m;
  int               ch_m;

  logic [NumCh-1:0] prev_oe = '0;
  int               rel_c;
  rec_t             mon_a;
  rec_t             mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NumCh; i++) base_m[i] = (1 << CntW) - 1;
    touch_m = '0;
    cal_m   = 1'b0;
    scans_m = 0;
    ch_m    = 0;
  endfunction

  // Expected result of one measurement on pad ch, with calibration/touch bookkeeping.
  function automatic void model_store(input int ch);
    int   seen;
    int   cnt;
    logic to;
    rec_t e;
    seen = r_act[ch] + 1;
    if (g_act[ch] != 0 && (g_act[ch] + 2) % TickDiv == 0 && (g_act[ch] + 2) / TickDiv < seen)
      seen = (g_act[ch] + 2) / TickDiv;
    cnt = seen - 1;
    to  = 1'b0;
    if (cnt >= Timeout) begin
      cnt = Timeout;
      to  = 1'b1;
    end
    if (!cal_m) begin
      if (cnt < base_m[ch]) base_m[ch] = cnt;
    end else if (cnt >= base_m[ch] + Thresh) begin
      touch_m[ch] = 1'b1;
    end else if (cnt < base_m[ch] + Thresh - Hyst) begin
      touch_m[ch] = 1'b0;
    end
    e.sd = (ch == NumCh - 1);
    if (e.sd && !cal_m) begin
      scans_m++;
      if (scans_m == CalScans) cal_m = 1'b1;
    end
    e.ch      = 3'(ch);
    e.cnt     = CntW'(cnt);
    e.to      = to;
    e.touched = touch_m;
    e.cal     = cal_m;
    exp_q.push_back(e);
    ch_m = (ch_m + 1) % NumCh;
  endfunction

  // Pad model: discharged while driven, rises r ticks (plus half a tick) after release.
  always @(negedge clk) begin
    if (rst_n && prev_oe != '0 && drive_oe == '0) begin
      rel_c = 0;
      for (int i = 0; i < NumCh; i++) if (prev_oe[i]) rel_c = i;
      check("release_order", 64'(rel_c), 64'(ch_m));
      r_act[ch_m] = r_next[ch_m];
      g_act[ch_m] = g_next[ch_m];
      model_store(ch_m);
      last_rel_ch = rel_c;
      nrel++;
    end
    for (int i = 0; i < NumCh; i++) begin
      if (drive_oe[i]) begin
        rel[i]   = 0;
        sense[i] = 1'b0;
      end else begin
        if (rel[i] < 100000) rel[i]++;
        sense[i] = (rel[i] > r_act[i] * TickDiv + TickDiv / 2) ||
                   (g_act[i] != 0 && rel[i] == g_act[i]);
      end
    end
    prev_oe = rst_n ? drive_oe : '0;
  end

  // Monitor: every count_valid must match the oldest predicted record.
  always @(negedge clk) begin
    if (rst_n && count_valid) begin
      nvalid++;
      if (scan_done) nscan++;
      mon_a = {count_ch, count_out, timeout, touched, cal_done, scan_done};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got %0h, expected no output", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        check("store_record", 64'(mon_a), 64'(mon_e));
      end
    end else if (rst_n && scan_done) begin
      checks++;
      errors++;
      $display("FAIL scan_done_alone: got 1, expected 0 without count_valid");
    end
  end

  task automatic wait_scans(input int n);
    int target;
    int cyc;
    target = nscan + n;
    cyc    = 0;
    while (nscan < target && cyc < n * ScanBudget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (nscan < target) begin
      checks++;
      errors++;
      $display("FAIL wait_scans: got %0d scans, expected %0d", nscan, target);
    end
  endtask

  task automatic wait_release(input int c);
    int seen;
    int cyc;
    bit hit;
    seen = nrel;
    cyc  = 0;
    hit  = 1'b0;
    while (!hit && cyc < 2 * ScanBudget) begin
      @(negedge clk);
      #1;
      cyc++;
      if (nrel != seen && last_rel_ch == c) hit = 1'b1;
      seen = nrel;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_release: got no release, expected release of ch%0d", c);
    end
  endtask

  // Watches for a quiet interval: drive_oe must stay low and no results appear.
  task automatic check_quiet(input string name, input int ticks);
    logic [NumCh-1:0] oe_seen;
    int               v0;
    oe_seen = '0;
    v0      = nvalid;
    repeat (ticks * TickDiv) begin
      @(negedge clk);
      oe_seen |= drive_oe;
    end
    check({name, "_drive"}, 64'(oe_seen), 64'(0));
    check({name, "_valid"}, 64'(nvalid - v0), 64'(0));
  endtask

  task automatic start_session();
    check("queue_empty_at_start", 64'(exp_q.size()), 64'(0));
    model_reset();
    enable = 1'b1;
  endtask

  task automatic set_all(input int r);
    for (int i = 0; i < NumCh; i++) begin
      r_next[i] = r;
      g_next[i] = 0;
    end
  endtask

  task automatic randomize_pads(input int lo, input int hi, input bit glitches);
    int k;
    for (int i = 0; i < NumCh; i++) begin
      r_next[i] = int'($urandom_range(hi, lo));
      g_next[i] = 0;
      if (glitches && $urandom_range(3, 0) == 0) begin
        k = int'($urandom_range(12, 1));
        g_next[i] = ($urandom_range(1, 0) == 1) ? k * TickDiv - 2 : k * TickDiv + TickDiv / 2;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      r_act[i] = 5;
      g_act[i] = 0;
      rel[i]   = 0;
    end
    set_all(5);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({drive_oe, count_out, count_ch, count_valid, timeout, touched, cal_done, scan_done}),
          64'(0));
    rst_n = 1'b1;
    check_quiet("idle_after_reset", 4);

    // Calibration at a uniform rise of 5 ticks.
    @(negedge clk);
    #1;
    start_session();
    wait_scans(CalScans);
    check("cal_done_after_scans", 64'(cal_done), 64'(1));

    // Hysteresis on pad 2: 8 asserts, 7 holds, 6 releases.
    r_next[2] = 8;
    wait_scans(1);
    check("touch_assert", 64'(touched), 64'(4'b0100));
    r_next[2] = 7;
    wait_scans(1);
    check("touch_hold", 64'(touched), 64'(4'b0100));
    r_next[2] = 6;
    wait_scans(1);
    check("touch_release", 64'(touched), 64'(4'b0000));

    // Random rise times and glitches.
    for (int s = 0; s < 8; s++) begin
      randomize_pads(2, 12, 1'b1);
      wait_scans(1);
    end

    // Drop enable while channel 1 is sampling; that channel still completes.
    set_all(5);
    wait_release(1);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    begin
      int v0;
      int cyc;
      v0  = nvalid;
      cyc = 0;
      while (nvalid == v0 && cyc < ScanBudget) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("store_after_disable", 64'(nvalid - v0), 64'(1));
    end
    check_quiet("idle_after_disable", 6);

    // Re-enable with pad 1 stuck low: calibrates to TIMEOUT and never reads as touched.
    @(negedge clk);
    #1;
    randomize_pads(3, 8, 1'b0);
    r_next[1] = 400;
    start_session();
    for (int s = 0; s < CalScans + 2; s++) begin
      wait_scans(1);
      r_next[0] = int'($urandom_range(8, 3));
      r_next[3] = int'($urandom_range(8, 3));
    end
    check("stuck_pad_untouched", 64'(touched[1]), 64'(0));
    check("stuck_cal_done", 64'(cal_done), 64'(1));

    // Directed glitches: one aligned to the 3rd sample tick, one between ticks.
    set_all(6);
    g_next[0] = 3 * TickDiv - 2;
    g_next[3] = 2 * TickDiv + TickDiv / 2;
    wait_scans(2);
    set_all(5);

    // Asynchronous reset while driving.
    begin
      int cyc;
      cyc = 0;
      while (drive_oe == '0 && cyc < ScanBudget) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("drive_seen_before_reset", 64'(drive_oe != '0), 64'(1));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_drive_async", 64'(drive_oe), 64'(0));
    check("reset_mid_outputs",
          64'({count_out, count_ch, count_valid, timeout, touched, cal_done, scan_done}),
          64'(0));
    enable = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    check_quiet("idle_after_midreset", 4);
    @(negedge clk);
    #1;
    start_session();
    wait_scans(1);

    enable = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < ScanBudget) begin
        @(negedge clk);
        cyc++;
      end
    end
    repeat (2 * TickDiv) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
